// File: rtl/lutbank_pkg.sv
// Shared types and constants for the LUT4 bank: config FSM states, truth-table widths
// and the select-field width helper.
package lutbank_pkg;

    localparam int unsigned TT_W  = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // Width of a field selecting one of n items; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lutbank_rr_arb.sv
// Combinational round-robin arbiter: grants the first valid requester at or after
// ptr+1 (mod NREQ). The pointer register lives in the parent.
module lutbank_rr_arb
    import lutbank_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned ID_W = sel_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] id
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!found && req[ID_W'(cand)]) begin
                found               = 1'b1;
                gnt[ID_W'(cand)]    = 1'b1;
                id                  = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/lutbank_arb.sv
// Run-time programmable LUT4 bank with bit-serial loading and a round-robin shared
// evaluator. Define LUTBANK_READBACK_EN to add the rb_sel/rb_data readback port.
module lutbank_arb
    import lutbank_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NLUT = 8,
    localparam int unsigned SEL_W = sel_w(NLUT),
    localparam int unsigned ID_W  = sel_w(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic                    cfg_bit,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*SEL_W-1:0]   req_sel,
    input  logic [NREQ*IDX_W-1:0]   req_idx,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_o
`ifdef LUTBANK_READBACK_EN
    ,
    input  logic [SEL_W-1:0]        rb_sel,
    output logic [TT_W-1:0]         rb_data
`endif
);

    cfg_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [TT_W-1:0]   shadow, shadow_nxt;
    logic [SEL_W-1:0]  tgt, tgt_nxt;
    logic              commit;

    logic [TT_W-1:0]   tbl [NLUT];
    logic [ID_W-1:0]   ptr;
    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gid;
    logic [SEL_W-1:0]  lk_sel;
    logic [IDX_W-1:0]  lk_idx;

    // Config state register; cfg_ready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            tgt       <= '0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            tgt       <= tgt_nxt;
            cfg_ready <= (state_nxt != COMMIT);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        tgt_nxt    = tgt;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_valid) begin
                    tgt_nxt    = cfg_sel;
                    shadow_nxt = {shadow[TT_W-2:0], cfg_bit};
                    cnt_nxt    = CNT_W'(1);
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (cfg_valid) begin
                    shadow_nxt = {shadow[TT_W-2:0], cfg_bit};
                    cnt_nxt    = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(TT_W - 1)) state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Truth-table storage; a commit and a lookup in the same cycle see the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NLUT); i++) tbl[i] <= '0;
        end else if (commit) begin
            tbl[tgt] <= shadow;
        end
    end

    lutbank_rr_arb #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .id  (gid)
    );

    assign req_ready = gnt;
    assign lk_sel    = req_sel[32'(gid)*SEL_W +: SEL_W];
    assign lk_idx    = req_idx[32'(gid)*IDX_W +: IDX_W];

    // Evaluator: one granted lookup per cycle, result one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= ID_W'(NREQ - 1);
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_o     <= 1'b0;
        end else begin
            rsp_valid <= |req_valid;
            if (|req_valid) begin
                ptr    <= gid;
                rsp_id <= gid;
                rsp_o  <= tbl[lk_sel][lk_idx];
            end
        end
    end

`ifdef LUTBANK_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rb_data <= '0;
        else        rb_data <= tbl[rb_sel];
    end
`endif

endmodule

// File: tb/tb_lutbank_arb.sv
// Scoreboard bench for lutbank_arb: a table/round-robin reference model predicts each
// grant and response; a separate monitor pops and compares responses.
module tb_lutbank_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned NLUT = 8;
    localparam int unsigned SW   = 3;
    localparam int unsigned IW   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_valid, cfg_ready, cfg_bit;
    logic [SW-1:0]       cfg_sel;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*SW-1:0]  req_sel;
    logic [NREQ*4-1:0]   req_idx;
    logic                rsp_valid, rsp_o;
    logic [IW-1:0]       rsp_id;
`ifdef LUTBANK_READBACK_EN
    logic [SW-1:0]       rb_sel;
    logic [15:0]         rb_data;
`endif

    logic [NREQ-1:0] rv;
    logic [SW-1:0]   rs [NREQ];
    logic [3:0]      ri [NREQ];

    typedef struct packed {
        logic [IW-1:0] id;
        logic          o;
    } exp_t;
    exp_t q[$];

    logic [15:0]     m_tbl [NLUT];
    int              m_ptr, m_beats;
    bit              m_pending;
    logic [SW-1:0]   m_tgt;
    logic [15:0]     m_shadow;
    logic [NREQ-1:0] g_last;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = rv;
        req_sel   = '0;
        req_idx   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_sel[i*SW +: SW] = rs[i];
            req_idx[i*4 +: 4]   = ri[i];
        end
    end

    lutbank_arb #(.NREQ(NREQ), .NLUT(NLUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_bit   (cfg_bit),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_o     (rsp_o)
`ifdef LUTBANK_READBACK_EN
        ,
        .rb_sel    (rb_sel),
        .rb_data   (rb_data)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated just before each rising edge with settled inputs.
    initial begin : model
        logic [NREQ-1:0] eg;
        int gi, c;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) begin
                for (int i = 0; i < int'(NLUT); i++) m_tbl[i] = '0;
                m_ptr = NREQ - 1; m_beats = 0; m_pending = 0;
                m_shadow = '0; m_tgt = '0; g_last = '0;
            end else begin
                eg = '0; gi = -1;
                for (int k = 1; k <= int'(NREQ); k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (gi < 0 && rv[c]) gi = c;
                end
                if (gi >= 0) eg[gi] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(eg));
                chk("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
                g_last = eg;
                if (gi >= 0) begin
                    q.push_back('{id: IW'(gi), o: m_tbl[rs[gi]][ri[gi]]});
                    m_ptr = gi;
                end
                if (m_pending) begin
                    m_tbl[m_tgt] = m_shadow;
                    m_pending = 0;
                    m_beats = 0;
                end else if (cfg_valid) begin
                    if (m_beats == 0) m_tgt = cfg_sel;
                    m_shadow = {m_shadow[14:0], cfg_bit};
                    m_beats++;
                    if (m_beats == 16) m_pending = 1;
                end
            end
        end
    end

    // Monitor: every response must match the oldest prediction, exactly one cycle later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                q.delete();
            end else if (rsp_valid) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp_unexpected id=%0d o=%0b expected=none t=%0t", rsp_id, rsp_o, $time);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_o", 32'(rsp_o), 32'(e.o));
                end
            end else if (q.size() != 0) begin
                checks++; failures++;
                $display("FAIL rsp_missing rsp_valid=0 expected=1 pending=%0d t=%0t", q.size(), $time);
                q.delete();
            end
        end
    end

    // Drop each requester once granted; bounded wait.
    task automatic drain();
        int n;
        n = 0;
        while (rv != '0 && n < 40) begin
            @(negedge clk);
            rv = rv & ~g_last;
            n++;
        end
        if (rv != '0) begin
            checks++; failures++;
            $display("FAIL drain_timeout rv=%b expected=0", rv);
            rv = '0;
        end
    endtask

    task automatic lookup(input int r, input logic [SW-1:0] sel, input logic [3:0] idx);
        @(negedge clk);
        rv[r] = 1'b1; rs[r] = sel; ri[r] = idx;
        drain();
    endtask

    task automatic load(input logic [SW-1:0] sel, input logic [15:0] val,
                        input bit gaps, input int nbeats, input bit probe);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    cfg_valid = 1'b0;
                    cfg_bit   = 1'($urandom);
                end
            end
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_sel   = (b == 0) ? sel : SW'($urandom);
            cfg_bit   = val[15-b];
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        if (probe) begin
            // Lookup granted in the COMMIT cycle, then again right after it.
            rv[0] = 1'b1; rs[0] = sel; ri[0] = 4'd1;
            @(negedge clk);
            @(negedge clk);
            rv[0] = 1'b0;
        end
    endtask

    task automatic random_reqs(input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (rv[i] && g_last[i]) begin
                    rv[i] = 1'($urandom);
                    rs[i] = SW'($urandom);
                    ri[i] = 4'($urandom);
                end else if (!rv[i] && ($urandom_range(0, 2) == 0)) begin
                    rv[i] = 1'b1;
                    rs[i] = SW'($urandom);
                    ri[i] = 4'($urandom);
                end
            end
        end
        @(negedge clk);
        rv = '0;
    endtask

    initial begin
        cfg_valid = 1'b0; cfg_sel = '0; cfg_bit = 1'b0; rv = '0;
        for (int i = 0; i < int'(NREQ); i++) begin rs[i] = '0; ri[i] = '0; end
`ifdef LUTBANK_READBACK_EN
        rb_sel = '0;
`endif
        repeat (3) @(negedge clk);
        #3;
        chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_o", 32'(rsp_o), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters on cleared table 0, idx F: grants 0,1,2,3 back to back.
        @(negedge clk);
        for (int i = 0; i < int'(NREQ); i++) begin rv[i] = 1'b1; rs[i] = '0; ri[i] = 4'hF; end
        drain();

        load(3'd3, 16'hCAFE, 1'b0, 16, 1'b0);
        lookup(2, 3'd3, 4'd1);
        lookup(2, 3'd3, 4'd0);
        lookup(2, 3'd3, 4'hF);

        load(3'd3, 16'h0000, 1'b0, 16, 1'b1);

        // Requesters 1 and 3 held continuously.
        @(negedge clk);
        rv[1] = 1'b1; rs[1] = 3'd0; ri[1] = 4'd2;
        rv[3] = 1'b1; rs[3] = 3'd3; ri[3] = 4'd5;
        repeat (8) @(negedge clk);
        rv = '0;

        // Reset after 9 beats of a load.
        load(3'd6, 16'hFFFF, 1'b0, 9, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lookup(1, 3'd6, 4'hF);
        lookup(1, 3'd6, 4'h0);
        load(3'd6, 16'h8000, 1'b0, 16, 1'b0);
        lookup(0, 3'd6, 4'hF);
        lookup(0, 3'd6, 4'hE);

        // Random loads with gaps concurrent with random lookups.
        fork
            begin
                for (int n = 0; n < 6; n++)
                    load(SW'($urandom), 16'($urandom), 1'b1, 16, 1'b0);
            end
            random_reqs(300);
        join

`ifdef LUTBANK_READBACK_EN
        load(3'd5, 16'h1234, 1'b0, 16, 1'b0);
        @(negedge clk);
        rb_sel = 3'd5;
        @(negedge clk);
        #1;
        chk("rb_data", 32'(rb_data), 32'h1234);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
